// File: rtl/pq_op_sequencer.sv
// Round-robin operation sequencer sharing one max-first priority queue between NUM_REQ requesters.
// Optional statistics counters (o_stat_ops, o_stat_errs) are built when PQ_SEQ_STATS_EN is defined.
module pq_op_sequencer #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 8,
  parameter int ENQ_WAIT   = QUEUE_SIZE / 2,
  parameter int RD_WAIT    = 1
) (
  input  logic                           i_CLK,
  input  logic                           i_RSTn,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [2*NUM_REQ-1:0]           i_req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [DATA_WIDTH-1:0]          o_rsp_data,
  output logic                           o_rsp_err,
  output logic                           o_busy,
  output logic                           o_pq_wrt,
  output logic                           o_pq_read,
  output logic [DATA_WIDTH-1:0]          o_pq_data,
`ifdef PQ_SEQ_STATS_EN
  output logic [15:0]                    o_stat_ops,
  output logic [15:0]                    o_stat_errs,
`endif
  input  logic                           i_pq_full,
  input  logic                           i_pq_empty,
  input  logic [DATA_WIDTH-1:0]          i_pq_data
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_W  = (ENQ_WAIT > RD_WAIT) ? ENQ_WAIT : RD_WAIT;
  localparam int CNT_W  = $clog2(MAX_W + 1);

  if (NUM_REQ < 2 || QUEUE_SIZE < 1) begin : g_param_check
    $error("pq_op_sequencer: NUM_REQ must be >= 2 and QUEUE_SIZE >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {OP_RSVD = 2'b00, OP_ENQ = 2'b01, OP_DEQ = 2'b10, OP_REPL = 2'b11} op_e;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  cap_q, cap_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_valid && i_req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // State register.
  always_ff @(posedge i_CLK) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (!i_RSTn) begin
      // NOTE: the small datapath registers are reset too, so RESP can never present stale data.
      state_q  <= S_IDLE;
      op_q     <= OP_RSVD;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      id_q     <= '0;
      data_q   <= '0;
      cap_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      data_q   <= data_d;
      cap_q    <= cap_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_d     = op_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    cap_d    = cap_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          state_d  = S_ISSUE;
          rr_ptr_d = grant_id;
          id_d     = grant_id;
          op_d     = op_e'(i_req_op[2*grant_id +: 2]);
          data_d   = i_req_data[DATA_WIDTH*grant_id +: DATA_WIDTH];
        end
      end
      S_ISSUE: begin
        err_d = 1'b0;
        cap_d = '0;
        unique case (op_q)
          OP_ENQ: begin
            if (i_pq_full) err_d = 1'b1;
            else           cnt_d = CNT_W'(ENQ_WAIT);
          end
          OP_DEQ: begin
            if (i_pq_empty) begin
              err_d = 1'b1;
            end else begin
              cap_d = i_pq_data;
              cnt_d = CNT_W'(RD_WAIT);
            end
          end
          OP_REPL: begin
            cap_d = i_pq_empty ? '0 : i_pq_data;
            cnt_d = CNT_W'(RD_WAIT);
          end
          default: err_d = 1'b1;
        endcase
        state_d = err_d ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    o_rsp_err   = 1'b0;
    o_pq_wrt    = 1'b0;
    o_pq_read   = 1'b0;
    o_pq_data   = '0;
    o_busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) o_req_ready[grant_id] = 1'b1;
      end
      S_ISSUE: begin
        unique case (op_q)
          OP_ENQ:  o_pq_wrt  = !i_pq_full;
          OP_DEQ:  o_pq_read = !i_pq_empty;
          OP_REPL: begin
            o_pq_wrt  = 1'b1;
            o_pq_read = 1'b1;
          end
          default: ;
        endcase
        if (o_pq_wrt || o_pq_read) o_pq_data = data_q;
      end
      S_RESP: begin
        o_rsp_valid[id_q] = 1'b1;
        o_rsp_data        = cap_q;
        o_rsp_err         = err_q;
      end
      default: ;
    endcase
  end

`ifdef PQ_SEQ_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  // Saturating counters, bumped once per response.
  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
    if (state_q == S_RESP) begin
      if (stat_ops_q != '1)           stat_ops_d  = stat_ops_q + 16'd1;
      if (err_q && stat_errs_q != '1) stat_errs_d = stat_errs_q + 16'd1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign o_stat_ops  = stat_ops_q;
  assign o_stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_pq_op_sequencer.sv
// Directed self-checking bench for pq_op_sequencer with a behavioural max-first queue model.
module tb_pq_op_sequencer;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int QS = 8;
  localparam logic [1:0] ENQ  = 2'b01;
  localparam logic [1:0] DEQ  = 2'b10;
  localparam logic [1:0] REPL = 2'b11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [2*NR-1:0] req_op = '0;
  logic [DW*NR-1:0] req_data = '0;
  logic [NR-1:0]  req_ready, rsp_valid;
  logic [DW-1:0]  rsp_data, pq_data, pq_head;
  logic           rsp_err, busy, pq_wrt, pq_read, pq_full, pq_empty;
`ifdef PQ_SEQ_STATS_EN
  logic [15:0]    stat_ops, stat_errs;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q_mem [QS] = '{default: '0};
  int            q_cnt = 0;

  always #5 clk = ~clk;

  pq_op_sequencer #(.NUM_REQ(NR), .DATA_WIDTH(DW), .QUEUE_SIZE(QS)) dut (
    .i_CLK       (clk),
    .i_RSTn      (rst_n),
    .i_req_valid (req_valid),
    .i_req_op    (req_op),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_busy      (busy),
    .o_pq_wrt    (pq_wrt),
    .o_pq_read   (pq_read),
    .o_pq_data   (pq_data),
`ifdef PQ_SEQ_STATS_EN
    .o_stat_ops  (stat_ops),
    .o_stat_errs (stat_errs),
`endif
    .i_pq_full   (pq_full),
    .i_pq_empty  (pq_empty),
    .i_pq_data   (pq_head)
  );

  assign pq_full  = (q_cnt == QS);
  assign pq_empty = (q_cnt == 0);
  assign pq_head  = (q_cnt > 0) ? q_mem[0] : '0;

  // Sorted-array queue: a read pops the head, a write inserts in descending order.
  always @(posedge clk) begin : pq_model
    logic [DW-1:0] t [QS];
    int c, p;
    t = q_mem;
    c = q_cnt;
    if (pq_read && c > 0) begin
      for (int i = 0; i < QS - 1; i++) t[i] = t[i+1];
      c--;
    end
    if (pq_wrt && c < QS) begin
      p = c;
      while (p > 0 && t[p-1] < pq_data) begin
        t[p] = t[p-1];
        p--;
      end
      t[p] = pq_data;
      c++;
    end
    q_mem <= t;
    q_cnt <= c;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic issue(input int r, input logic [1:0] op, input logic [DW-1:0] d,
                       input int exp_lat, input logic exp_wrt, input logic exp_rd,
                       input logic [DW-1:0] exp_data, input logic exp_err, input string nm);
    int lat;
    logic [NR-1:0] exp_oh;
    logic [DW-1:0] exp_pd;
    exp_oh = '0;
    exp_oh[r] = 1'b1;
    exp_pd = (exp_wrt || exp_rd) ? d : '0;
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_op[2*r +: 2] = op;
    req_data[DW*r +: DW] = d;
    #1;
    checks++;
    if (req_ready !== exp_oh) begin
      errors++;
      $display("FAIL %s ready: got %b exp %b", nm, req_ready, exp_oh);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[r] = 1'b0;
    checks++;
    if ({pq_wrt, pq_read} !== {exp_wrt, exp_rd}) begin
      errors++;
      $display("FAIL %s strobes: got wrt=%b rd=%b exp wrt=%b rd=%b", nm, pq_wrt, pq_read, exp_wrt, exp_rd);
    end
    checks++;
    if (pq_data !== exp_pd) begin
      errors++;
      $display("FAIL %s pq_data: got %h exp %h", nm, pq_data, exp_pd);
    end
    lat = 1;
    while (rsp_valid === '0 && lat < 40) begin
      @(negedge clk);
      lat++;
      checks++;
      if ({pq_wrt, pq_read} !== 2'b00) begin
        errors++;
        $display("FAIL %s strobe_outside_issue: got wrt=%b rd=%b at +%0d", nm, pq_wrt, pq_read, lat);
      end
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d exp %0d", nm, lat, exp_lat);
    end
    checks++;
    if (rsp_valid !== exp_oh) begin
      errors++;
      $display("FAIL %s rsp_valid: got %b exp %b", nm, rsp_valid, exp_oh);
    end
    checks++;
    if ({rsp_err, rsp_data} !== {exp_err, exp_data}) begin
      errors++;
      $display("FAIL %s rsp: got err=%b data=%0d exp err=%b data=%0d", nm, rsp_err, rsp_data, exp_err, exp_data);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL %s after_resp: got rsp_valid=%b busy=%b exp 0", nm, rsp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, busy, pq_wrt, pq_read} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b rsp=%b err=%b busy=%b wrt=%b rd=%b exp 0",
               req_ready, rsp_valid, rsp_err, busy, pq_wrt, pq_read);
    end
    checks++;
    if ({rsp_data, pq_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rsp_data=%h pq_data=%h exp 0", rsp_data, pq_data);
    end
`ifdef PQ_SEQ_STATS_EN
    checks++;
    if ({stat_ops, stat_errs} !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got ops=%0d errs=%0d exp 0", stat_ops, stat_errs);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_enq();
    issue(0, ENQ, 16'h0123, 6, 1'b1, 1'b0, 16'd0, 1'b0, "enq_0123");
  endtask

  task automatic test_deq();
    issue(0, DEQ, 16'd0, 3, 1'b0, 1'b1, 16'h0123, 1'b0, "deq_0123");
    issue(1, ENQ, 16'd300, 6, 1'b1, 1'b0, 16'd0, 1'b0, "enq_300");
    issue(3, ENQ, 16'd500, 6, 1'b1, 1'b0, 16'd0, 1'b0, "enq_500");
    issue(2, DEQ, 16'd0, 3, 1'b0, 1'b1, 16'd500, 1'b0, "deq_500");
    checks++;
    if (pq_head !== 16'd300) begin
      errors++;
      $display("FAIL deq_next_head: got %0d exp 300", pq_head);
    end
    issue(0, DEQ, 16'd0, 3, 1'b0, 1'b1, 16'd300, 1'b0, "deq_300");
  endtask

  task automatic test_empty();
    issue(1, DEQ, 16'd0, 2, 1'b0, 1'b0, 16'd0, 1'b1, "deq_empty");
    issue(2, REPL, 16'd77, 3, 1'b1, 1'b1, 16'd0, 1'b0, "repl_empty");
    checks++;
    if (pq_head !== 16'd77) begin
      errors++;
      $display("FAIL repl_head: got %0d exp 77", pq_head);
    end
    issue(0, DEQ, 16'd0, 3, 1'b0, 1'b1, 16'd77, 1'b0, "deq_77");
  endtask

  task automatic test_full();
    for (int i = 0; i < QS; i++)
      issue(i % NR, ENQ, DW'(10 * (i + 1)), 6, 1'b1, 1'b0, 16'd0, 1'b0, "fill");
    checks++;
    if (pq_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got %b exp 1", pq_full);
    end
`ifdef PQ_SEQ_STATS_EN
    checks++;
    if ({stat_ops, stat_errs} !== {16'd17, 16'd1}) begin
      errors++;
      $display("FAIL stats_before_full: got ops=%0d errs=%0d exp 17/1", stat_ops, stat_errs);
    end
`endif
    issue(3, ENQ, 16'd9, 2, 1'b0, 1'b0, 16'd0, 1'b1, "enq_full");
`ifdef PQ_SEQ_STATS_EN
    checks++;
    if ({stat_ops, stat_errs} !== {16'd18, 16'd2}) begin
      errors++;
      $display("FAIL stats_after_full: got ops=%0d errs=%0d exp 18/2", stat_ops, stat_errs);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int ng, nr, last;
    logic [NR-1:0] exp_oh;
    ng = 0;
    nr = 0;
    last = 0;
    @(negedge clk);
    req_op = {NR{DEQ}};
    req_data = '0;
    req_valid = '1;
    for (int cyc = 0; cyc < 80 && nr < 8; cyc++) begin
      #1;
      if (req_ready !== '0) begin
        exp_oh = '0;
        exp_oh[ng % NR] = 1'b1;
        checks++;
        if (req_ready !== exp_oh) begin
          errors++;
          $display("FAIL b2b_grant%0d: got %b exp %b", ng, req_ready, exp_oh);
        end
        if (ng > 0) begin
          checks++;
          if (cyc - last !== 4) begin
            errors++;
            $display("FAIL b2b_spacing%0d: got %0d exp 4", ng, cyc - last);
          end
        end
        last = cyc;
        ng++;
      end else if (ng == 8) begin
        req_valid = '0;
      end
      if (rsp_valid !== '0) begin
        exp_oh = '0;
        exp_oh[nr % NR] = 1'b1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {exp_oh, 1'b0, DW'(80 - 10 * nr)}) begin
          errors++;
          $display("FAIL b2b_rsp%0d: got id=%b err=%b data=%0d exp id=%b err=0 data=%0d",
                   nr, rsp_valid, rsp_err, rsp_data, exp_oh, 80 - 10 * nr);
        end
        nr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (ng !== 8 || nr !== 8) begin
      errors++;
      $display("FAIL b2b_count: got grants=%0d rsps=%0d exp 8/8", ng, nr);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int lat;
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_op[3:2] = ENQ;
    req_data[31:16] = 16'd5;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_grant1: got %b exp 0010", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (pq_wrt !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wrt: got %b exp 1", pq_wrt);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wait_busy: got %b exp 1", busy);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, busy, pq_wrt, pq_read, rsp_data, pq_data} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got ready=%b rsp=%b err=%b busy=%b wrt=%b rd=%b data=%h pqd=%h exp 0",
               req_ready, rsp_valid, rsp_err, busy, pq_wrt, pq_read, rsp_data, pq_data);
    end
`ifdef PQ_SEQ_STATS_EN
    checks++;
    if ({stat_ops, stat_errs} !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_stats: got ops=%0d errs=%0d exp 0", stat_ops, stat_errs);
    end
`endif
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== '0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_rsp: got response=1 exp 0");
    end
    checks++;
    if (pq_head !== 16'd5) begin
      errors++;
      $display("FAIL rstmid_head: got %0d exp 5", pq_head);
    end
    req_op = {DEQ, DEQ, DEQ, DEQ};
    req_valid = 4'b0101;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_regrant: got %b exp 0001", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    lat = 0;
    while (rsp_valid === '0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {4'b0001, 1'b0, 16'd5} || lat !== 3) begin
      errors++;
      $display("FAIL rstmid_deq: got id=%b err=%b data=%0d lat=%0d exp id=0001 err=0 data=5 lat=3",
               rsp_valid, rsp_err, rsp_data, lat);
    end
  endtask

  initial begin
    test_reset();
    test_enq();
    test_deq();
    test_empty();
    test_full();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
